// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches words over a req/rvalid handshake
// and selects the next PC from br_sel/ALU. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        br_sel_i,
  input  logic [31:0] alu_data_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_four_o,
  output logic        instr_valid_o,
  output logic        misalign_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt_o,
  output logic [31:0] wait_cnt_o
`endif
);

  typedef enum logic [1:0] {FETCH, VALID, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] next_pc;

  // JALR rule: target bit 0 is always cleared
  assign next_pc = br_sel_i ? (alu_data_i & ~32'd1) : pc_q + 32'd4;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      FETCH: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall_i) begin
          pc_d = next_pc;
          if (next_pc[1]) begin
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: ; // TRAP is left only through reset
    endcase
  end

  // outputs are forced to their idle values while reset is held
  assign imem_req_o    = rst_ni && (state_q == FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = rst_ni && (state_q == VALID);
  assign instr_o       = instr_valid_o ? instr_q : NOP_INSTR;
  assign pc_o          = rst_ni ? pc_q : RESET_PC;
  assign pc_four_o     = pc_o + 32'd4;
  assign misalign_o    = rst_ni && misalign_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      retired_cnt_o <= 32'd0;
      wait_cnt_o    <= 32'd0;
    end else begin
      if (state_q == VALID && !stall_i)        retired_cnt_o <= retired_cnt_o + 32'd1;
      if (state_q == FETCH && !imem_rvalid_i)  wait_cnt_o    <= wait_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC-sequence model pushes expected fetches,
// a monitor pops them as the DUT presents instructions or traps.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        br_sel_i = 1'b0;
  logic [31:0] alu_data_i = '0;
  logic        stall_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_o, pc_o, pc_four_o;
  logic        instr_valid_o, misalign_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt_o, wait_cnt_o;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .br_sel_i(br_sel_i), .alu_data_i(alu_data_i),
    .stall_i(stall_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
    .pc_o(pc_o), .pc_four_o(pc_four_o), .instr_valid_o(instr_valid_o),
    .misalign_o(misalign_o)
`ifdef FETCH_PERF_CNT_EN
    , .retired_cnt_o(retired_cnt_o), .wait_cnt_o(wait_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          trap;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          lat_mode = 0;
  bit          spurious_en = 0;
  int          last_lat = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_ret = 0;
  bit          trapped = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0000_0093 : ((a * 32'h9E37_79B1) ^ 32'h0000_0013);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory model: acts 2ns after the edge so it sees reset/req already settled
  int lat_left = 0;
  bit busy = 0;
  always begin
    @(posedge clk_i); #2;
    if (!rst_ni) begin
      busy = 0;
      imem_rvalid_i = 1'b0;
    end else if (imem_req_o) begin
      if (!busy) begin
        busy = 1;
        lat_left = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
        last_lat = lat_left;
      end
      if (lat_left == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(imem_addr_o);
        busy = 0;
      end else begin
        imem_rvalid_i = 1'b0;
        lat_left--;
      end
    end else begin
      busy = 0;
      imem_rvalid_i = spurious_en && ($urandom_range(0, 3) == 0);
      imem_rdata_i  = $urandom;
    end
  end

  // monitor
  bit          prev_valid = 0, prev_mis = 0;
  int          req_cnt = 0;
  logic [31:0] hold_pc, hold_instr;
  logic [31:0] exp_wait = 0;
  exp_t        e;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_req", {31'd0, imem_req_o}, 0);
      chk("rst_valid", {31'd0, instr_valid_o}, 0);
      chk("rst_misalign", {31'd0, misalign_o}, 0);
      chk("rst_instr", instr_o, NOP_INSTR);
      chk("rst_pc", pc_o, RESET_PC);
      prev_valid = 0; prev_mis = 0; req_cnt = 0; exp_wait = 0;
    end else begin
`ifdef FETCH_PERF_CNT_EN
      chk("retired_cnt", retired_cnt_o, exp_ret);
      chk("wait_cnt", wait_cnt_o, exp_wait);
      if (imem_req_o && !imem_rvalid_i) exp_wait++;
`endif
      chk("pc_four", pc_four_o, pc_o + 32'd4);
      if (imem_req_o) begin
        req_cnt++;
        if (q.size() > 0) chk("fetch_addr", imem_addr_o, q[0].pc);
      end
      if (!instr_valid_o) chk("nop_when_invalid", instr_o, NOP_INSTR);
      if (instr_valid_o && !prev_valid) begin
        if (q.size() == 0) chk("unexpected_instr", 1, 0);
        else begin
          e = q.pop_front();
          chk("kind_instr", {31'd0, e.trap}, 0);
          chk("instr", instr_o, e.instr);
          chk("pc", pc_o, e.pc);
          chk("pc_four_val", pc_four_o, e.pc + 32'd4);
          chk("fetch_cycles", req_cnt, last_lat + 1);
        end
        hold_pc = pc_o; hold_instr = instr_o; req_cnt = 0;
      end else if (instr_valid_o) begin
        chk("hold_pc", pc_o, hold_pc);
        chk("hold_instr", instr_o, hold_instr);
        chk("valid_no_req", {31'd0, imem_req_o}, 0);
      end
      if (misalign_o && !prev_mis) begin
        if (q.size() == 0) chk("unexpected_trap", 1, 0);
        else begin
          e = q.pop_front();
          chk("kind_trap", {31'd0, e.trap}, 1);
          chk("trap_pc", pc_o, e.pc);
        end
        hold_pc = pc_o;
      end
      if (misalign_o) begin
        chk("trap_pc_hold", pc_o, hold_pc);
        chk("trap_req", {31'd0, imem_req_o}, 0);
        chk("trap_valid", {31'd0, instr_valid_o}, 0);
      end
      prev_valid = instr_valid_o;
      prev_mis = misalign_o;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    q.delete();
    exp_ret = 0;
    tick(); tick();
    rst_ni = 1'b1;
    exp_pc = RESET_PC;
    q.push_back('{trap: 1'b0, pc: RESET_PC, instr: mem_word(RESET_PC)});
    trapped = 0;
  endtask

  // wait for the current instruction, stall it, then consume with br/alu
  task automatic consume(input int stall_n, input logic br, input logic [31:0] alu);
    int          budget;
    logic [31:0] nxt;
    budget = 0;
    while (!instr_valid_o && budget < 60) begin
      stall_i = 1'b1; tick(); budget++;
    end
    if (!instr_valid_o) begin
      chk("valid_timeout", 0, 1);
      trapped = 1;
      return;
    end
    for (int i = 0; i < stall_n; i++) begin
      stall_i = 1'b1; br_sel_i = $urandom_range(0, 1); alu_data_i = $urandom;
      tick();
    end
    stall_i = 1'b0; br_sel_i = br; alu_data_i = alu;
    nxt = br ? {alu[31:1], 1'b0} : exp_pc + 32'd4;
    exp_pc = nxt;
    if (nxt[1]) begin
      q.push_back('{trap: 1'b1, pc: nxt, instr: NOP_INSTR});
      trapped = 1;
    end else begin
      q.push_back('{trap: 1'b0, pc: nxt, instr: mem_word(nxt)});
    end
    tick();
    exp_ret++;
    stall_i = $urandom_range(0, 1); br_sel_i = $urandom_range(0, 1); alu_data_i = $urandom;
  endtask

  task automatic trap_reset();
    repeat (4) tick();
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          b;
    tick();
    do_reset();
    // directed scenarios
    lat_mode = 0;
    consume(0, 1'b0, 32'h0);               // pc 0 -> 4
    lat_mode = 2; spurious_en = 1;
    consume(0, 1'b0, 32'h0);               // 4 -> 8, slow fetch of 8
    consume(5, 1'b0, 32'h0);               // 8 stalled 5 cycles -> C
    lat_mode = -1;
    consume(0, 1'b1, 32'h10);              // -> 0x10
    consume(0, 1'b1, 32'h40);              // -> 0x40
    consume(1, 1'b1, 32'h41);              // JALR -> 0x40
    consume(0, 1'b1, 32'hFFFF_FFFC);
    consume(0, 1'b0, 32'h0);               // wraps to 0
    consume(0, 1'b1, 32'h22);              // misaligned -> trap
    trap_reset();
    consume(0, 1'b1, 32'h23);              // bit0 cleared, still misaligned
    trap_reset();
    lat_mode = 3;
    consume(0, 1'b0, 32'h0);               // reset while fetch of 4 pending
    tick(); tick();
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      if ($urandom_range(0, 15) != 0) a[1] = 1'b0;
      consume($urandom_range(0, 2), 1'($urandom_range(0, 1)), a);
      if (trapped) trap_reset();
    end
    b = 0;
    while (!instr_valid_o && b < 60) begin tick(); b++; end
    tick(); tick();
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
